// File: rtl/seq_defs.sv
// Shared definitions for the switch-driven instruction entry sequencer:
// FSM state encodings, the default debounce length and the latched-field record.
package seq_defs;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  localparam logic [1:0] S_REG  = 2'd0;
  localparam logic [1:0] S_OP   = 2'd1;
  localparam logic [1:0] S_IMM  = 2'd2;
  localparam logic [1:0] S_EXEC = 2'd3;

  typedef struct packed {
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [4:0]  opcode;
    logic        imm_s;
    logic [15:0] imm_val;
  } seq_fields_t;

  // Successor of S_OP depends on whether an immediate operand follows.
  function automatic logic [1:0] op_next_state(input logic imm_sel);
    return imm_sel ? S_IMM : S_EXEC;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low push button conditioner: 2-flop synchronizer, stable-level
// debounce counter and a single-cycle press pulse on each accepted 1->0 change.
module btn_debounce
  import seq_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             db_dly_q, db_dly_d;
  logic [1:0]       settle_q, settle_d;
  logic             arm_q, arm_d;
  logic             press_q, press_d;

  always_comb begin
    sync_d   = {sync_q[0], btn_raw_n};
    cnt_d    = '0;
    db_d     = db_q;
    db_dly_d = db_q;
    // A differing level must persist for DEBOUNCE_CYCLES samples; any
    // return to the accepted level drops the count back to zero.
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Arming requires a genuinely released button once the synchronizer holds
    // real samples, so a button held through reset never yields a press.
    settle_d = {settle_q[0], 1'b1};
    arm_d    = arm_q | (settle_q[1] & sync_q[1]);
    press_d  = arm_q & db_dly_q & ~db_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      db_q     <= 1'b1;
      db_dly_q <= 1'b1;
      settle_q <= 2'b00;
      arm_q    <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      settle_q <= settle_d;
      arm_q    <= arm_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/input_sequencer.sv
// Steps the operator through destination/source, opcode, optional immediate
// and execute entries on debounced button presses, latching switch fields.
module input_sequencer
  import seq_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  data_input,
  input  logic        btn_n,
  input  logic        btn_clr_n,
  output logic [3:0]  RdestLoc,
  output logic [3:0]  RsrcLoc,
  output logic [4:0]  OpCode,
  output logic        Imm_s,
  output logic [15:0] imm_val,
  output logic        En,
  output logic [1:0]  step
);

  logic        nxt_evt;
  logic        clr_evt;
  logic [1:0]  state_q, state_d;
  seq_fields_t fields_q, fields_d;
  logic        en_q, en_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_next (
    .clk       (clk),
    .rst       (rst),
    .btn_raw_n (btn_n),
    .press     (nxt_evt)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_clr (
    .clk       (clk),
    .rst       (rst),
    .btn_raw_n (btn_clr_n),
    .press     (clr_evt)
  );

  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    en_d     = 1'b0;
    // Clear wins over a coincident next press and never touches the fields.
    if (clr_evt) begin
      state_d = S_REG;
    end else if (nxt_evt) begin
      case (state_q)
        S_REG: begin
          fields_d.rdest = data_input[9:6];
          fields_d.rsrc  = data_input[3:0];
          state_d        = S_OP;
        end
        S_OP: begin
          fields_d.opcode = data_input[4:0];
          fields_d.imm_s  = data_input[9];
          state_d         = op_next_state(data_input[9]);
        end
        S_IMM: begin
          fields_d.imm_val = {6'b0, data_input};
          state_d          = S_EXEC;
        end
        default: begin
          en_d    = 1'b1;
          state_d = S_REG;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_REG;
      fields_q <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
      en_q     <= en_d;
    end
  end

  assign RdestLoc = fields_q.rdest;
  assign RsrcLoc  = fields_q.rsrc;
  assign OpCode   = fields_q.opcode;
  assign Imm_s    = fields_q.imm_s;
  assign imm_val  = fields_q.imm_val;
  assign En       = en_q;
  assign step     = state_q;

endmodule

// File: doc/input_sequencer.md
INPUT_SEQUENCER -- requirements
Module: input_sequencer

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 500000, the consecutive stable clock cycles (10 ms at 50 MHz) required to accept a button level change.
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 SHALL provide port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL provide port data_input, input, 10 bits: raw slide-switch value, sampled only on an accepted press.
REQ-006 SHALL provide port btn_n, input, 1 bit: raw, asynchronous, active-low "next" push button.
REQ-007 SHALL provide port btn_clr_n, input, 1 bit: raw, asynchronous, active-low "clear" push button.
REQ-008 SHALL provide port RdestLoc, output, 4 bits: registered destination register index.
REQ-009 SHALL provide port RsrcLoc, output, 4 bits: registered source register index.
REQ-010 SHALL provide port OpCode, output, 5 bits: registered opcode.
REQ-011 SHALL provide port Imm_s, output, 1 bit: registered immediate-select flag.
REQ-012 SHALL provide port imm_val, output, 16 bits: registered immediate value.
REQ-013 SHALL provide port En, output, 1 bit: one-cycle execute-enable pulse to the register-file/ALU.
REQ-014 SHALL provide port step, output, 2 bits: current FSM state encoding, driven to the board LEDs.

Function
REQ-015 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-016 SHALL change the debounced level only after the synchronized input holds the new level for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-017 SHALL generate exactly one single-cycle press event per debounced 1->0 transition; releases and held buttons generate none.
REQ-018 SHALL make latched fields visible DEBOUNCE_CYCLES+3 cycles after the first low sample of a clean press.
REQ-019 SHALL implement FSM states S_REG=0, S_OP=1, S_IMM=2, S_EXEC=3, exposed on step.
REQ-020 SHALL, on a press in S_REG, latch RdestLoc=data_input[9:6] and RsrcLoc=data_input[3:0], then go to S_OP.
REQ-021 SHALL, on a press in S_OP, latch OpCode=data_input[4:0] and Imm_s=data_input[9], then go to S_IMM if data_input[9]=1, else S_EXEC.
REQ-022 SHALL, on a press in S_IMM, latch imm_val={6'b0, data_input[9:0]}, then go to S_EXEC.
REQ-023 SHALL, on a press in S_EXEC, assert En for exactly one cycle, then return to S_REG.
REQ-024 SHALL hold En low in every other cycle, so there is never a two-cycle pulse.
REQ-025 SHALL, on a clear event in any state, return to S_REG without asserting En; all latched fields hold.
REQ-026 SHALL give clear priority when clear and next events occur in the same cycle; the next event is discarded.
REQ-027 SHALL hold all latched fields between presses and update them only in the states named above.

Reset
REQ-028 SHALL, while rst=1, force: state S_REG; RdestLoc, RsrcLoc, OpCode, imm_val = 0; Imm_s, En = 0; debounce counters = 0; synchronizer and debounced levels = 1 (released).
REQ-029 SHALL discard any debounce in progress when rst asserts mid-press; a button still held at rst release produces no event until it is released and pressed again.

Structure
REQ-030 SHALL place FSM state encodings and the DEBOUNCE_CYCLES default in a shared definitions file, seq_defs.
REQ-031 SHALL implement synchronizer, debounce counter and press-edge detect as sub-module btn_debounce, instantiated once per button.
REQ-032 SHALL size the debounce counter as clog2(DEBOUNCE_CYCLES+1) bits.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 SHALL verify: clean presses with switches 0x2C5, 0x203, 0x015, then an exec press -> RdestLoc=0xB, RsrcLoc=0x5, OpCode=0x03, Imm_s=1, imm_val=0x0015, one En pulse, step sequence 0,1,2,3,0.
REQ-034 SHALL verify: opcode press with data_input[9]=0 -> S_OP goes straight to S_EXEC (step 1->3); imm_val unchanged.
REQ-035 SHALL verify: btn_n glitch low for 3 cycles -> no event, step unchanged; a 200-cycle hold -> exactly one event.
REQ-036 SHALL verify: clear and next events in the same cycle while in S_IMM -> step=0, En never asserted, fields unchanged.
REQ-037 SHALL verify: rst pulsed mid-debounce with btn_n held low -> all outputs 0, step=0; no event until release and re-press.
REQ-038 SHALL verify: 100 random-bounce presses -> event count equals clean press count; En is never high for two consecutive cycles.
